fifo_wr_arbiter: RTL and testbench

Round-robin arbiter that shares the enqueue port of a single downstream fifo among N_REQ producers. Each producer presents a valid/ready/last stream. The block grants one producer at a time and holds the grant for a burst. The burst ends on last, on MAX_BURST beats, or when the owner withdraws. The block sits between producer agents and a fifo instance, driving that fifo's enqueue and wdata and observing its full.

---
 rtl/fifo_wr_arbiter.sv | 124 ++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one downstream fifo enqueue port among N_REQ
// valid/ready/last producers; grants are held for a burst of up to MAX_BURST beats.
module fifo_wr_arbiter #(
  parameter int N_REQ     = 4,
  parameter int WIDTH     = 32,
  parameter int MAX_BURST = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req_valid,
  input  logic [N_REQ-1:0]         req_last,
  input  logic [WIDTH-1:0]         req_data [N_REQ],
  output logic [N_REQ-1:0]         req_ready,
  input  logic                     fifo_full,
  output logic                     fifo_enqueue,
  output logic [WIDTH-1:0]         fifo_wdata,
  output logic                     grant_valid,
  output logic [$clog2(N_REQ)-1:0] grant_id
);

  localparam int IDW   = $clog2(N_REQ);
  localparam int IDW1  = IDW + 1;
  localparam int CNT_W = $clog2(MAX_BURST) + 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAX_BURST - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [IDW-1:0]   owner_q, owner_d;
  logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0] burst_cnt_q, burst_cnt_d;

  logic             pick_found;
  logic [IDW-1:0]   pick_idx;
  logic [IDW-1:0]   cand;
  logic             owner_valid;
  logic             owner_last;
  logic             beat;
  logic             rel;

  // Modular add that stays correct when N_REQ is not a power of two.
  function automatic logic [IDW-1:0] wrap_add(input logic [IDW-1:0] idx, input int step);
    logic [IDW1-1:0] s;
    s = {1'b0, idx} + IDW1'(step);
    if (s >= IDW1'(N_REQ)) begin
      s = s - IDW1'(N_REQ);
    end
    return s[IDW-1:0];
  endfunction

  always_comb begin
    pick_found = 1'b0;
    pick_idx   = rr_ptr_q;
    cand       = rr_ptr_q;
    for (int i = 0; i < N_REQ; i++) begin
      cand = wrap_add(rr_ptr_q, i);
      if (!pick_found && req_valid[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  assign owner_valid = req_valid[owner_q];
  assign owner_last  = req_last[owner_q];
  assign beat        = (state_q == GRANT) && owner_valid && !fifo_full;

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    rr_ptr_d     = rr_ptr_q;
    burst_cnt_d  = burst_cnt_q;
    req_ready    = '0;
    fifo_enqueue = 1'b0;
    fifo_wdata   = '0;
    grant_valid  = 1'b0;
    grant_id     = '0;
    rel          = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          owner_d     = pick_idx;
          burst_cnt_d = '0;
          state_d     = GRANT;
        end
      end
      GRANT: begin
        grant_valid        = 1'b1;
        grant_id           = owner_q;
        req_ready[owner_q] = !fifo_full;
        if (beat) begin
          fifo_enqueue = 1'b1;
          fifo_wdata   = req_data[owner_q];
          burst_cnt_d  = burst_cnt_q + CNT_W'(1);
        end
        // A withdrawn owner releases even while the fifo is stalling it.
        rel = !owner_valid || (beat && (owner_last || (burst_cnt_q == LAST_CNT)));
        if (rel) begin
          state_d  = IDLE;
          rr_ptr_d = wrap_add(owner_q, 1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      owner_q     <= '0;
      rr_ptr_q    <= '0;
      burst_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      rr_ptr_q    <= rr_ptr_d;
      burst_cnt_q <= burst_cnt_d;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: directed scenarios plus random traffic, all
// checked each cycle against a grant/burst-level model of the arbiter.
module tb_fifo_wr_arbiter;

  localparam int N_REQ     = 4;
  localparam int WIDTH     = 32;
  localparam int MAX_BURST = 4;
  localparam int IDW       = $clog2(N_REQ);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 rst;
  logic [N_REQ-1:0]     req_valid;
  logic [N_REQ-1:0]     req_last;
  logic [WIDTH-1:0]     req_data [N_REQ];
  logic [N_REQ-1:0]     req_ready;
  logic                 fifo_full;
  logic                 fifo_enqueue;
  logic [WIDTH-1:0]     fifo_wdata;
  logic                 grant_valid;
  logic [IDW-1:0]       grant_id;

  fifo_wr_arbiter #(.N_REQ(N_REQ), .WIDTH(WIDTH), .MAX_BURST(MAX_BURST)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_last(req_last), .req_data(req_data),
    .req_ready(req_ready),
    .fifo_full(fifo_full), .fifo_enqueue(fifo_enqueue), .fifo_wdata(fifo_wdata),
    .grant_valid(grant_valid), .grant_id(grant_id)
  );

  int tests = 0;
  int fails = 0;

  // Model: who owns the port, where the next search starts, beats taken so far.
  bit m_busy;
  int m_owner, m_ptr, m_beats;

  int pbeat [N_REQ];
  int cyc = 0;
  logic [WIDTH-1:0] enq_log [$];
  int enq_cyc [$];
  int grant_log [$];
  bit prev_gv;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_owner = 0; m_ptr = 0; m_beats = 0;
  endtask

  task automatic clear_logs();
    enq_log.delete(); enq_cyc.delete(); grant_log.delete();
    prev_gv = 0;
    for (int i = 0; i < N_REQ; i++) pbeat[i] = 0;
  endtask

  function automatic logic [63:0] enq_at(input int i);
    if (i < enq_log.size()) return 64'(enq_log[i]);
    return '1;
  endfunction

  function automatic logic [63:0] grant_at(input int i);
    if (i < grant_log.size()) return 64'(grant_log[i]);
    return '1;
  endfunction

  function automatic logic [63:0] enqcyc_at(input int i);
    if (i < enq_cyc.size()) return 64'(enq_cyc[i]);
    return '1;
  endfunction

  // Inputs are already driven; check this cycle, then advance past one edge.
  task automatic step();
    logic [N_REQ-1:0] acc, e_ready;
    logic [WIDTH-1:0] e_wd;
    bit beat, rel, n_busy;
    int n_owner, n_ptr, n_beats, c;
    #1;
    if (!rst) model_reset();
    beat    = m_busy && req_valid[m_owner] && !fifo_full;
    e_ready = (m_busy && !fifo_full) ? (N_REQ'(1) << m_owner) : '0;
    e_wd    = beat ? req_data[m_owner] : '0;
    chk("grant_valid", 64'(grant_valid), 64'(m_busy));
    chk("grant_id", 64'(grant_id), m_busy ? 64'(m_owner) : 64'd0);
    chk("req_ready", 64'(req_ready), 64'(e_ready));
    chk("fifo_enqueue", 64'(fifo_enqueue), 64'(beat));
    chk("fifo_wdata", 64'(fifo_wdata), 64'(e_wd));
    if (fifo_enqueue === 1'b1) begin
      enq_log.push_back(fifo_wdata);
      enq_cyc.push_back(cyc);
    end
    if (grant_valid === 1'b1 && !prev_gv) grant_log.push_back(int'(grant_id));
    prev_gv = (grant_valid === 1'b1);
    acc = req_valid & req_ready;

    n_busy = m_busy; n_owner = m_owner; n_ptr = m_ptr; n_beats = m_beats;
    if (!m_busy) begin
      for (int k = 0; k < N_REQ; k++) begin
        c = (m_ptr + k) % N_REQ;
        if (!n_busy && req_valid[c]) begin
          n_busy = 1; n_owner = c; n_beats = 0;
        end
      end
    end else begin
      if (beat) n_beats = m_beats + 1;
      rel = !req_valid[m_owner] ||
            (beat && (req_last[m_owner] || (m_beats + 1 == MAX_BURST)));
      if (rel) begin
        n_busy = 0;
        n_ptr  = (m_owner + 1) % N_REQ;
      end
    end

    @(posedge clk);
    if (rst) begin
      m_busy = n_busy; m_owner = n_owner; m_ptr = n_ptr; m_beats = n_beats;
      for (int i = 0; i < N_REQ; i++) if (acc[i] === 1'b1) pbeat[i]++;
    end else begin
      model_reset();
    end
    cyc++;
    #1;
  endtask

  task automatic idle_inputs();
    req_valid = '0; req_last = '0; fifo_full = 1'b0;
    for (int i = 0; i < N_REQ; i++) req_data[i] = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b0;
    step();
    rst = 1'b1;
    clear_logs();
  endtask

  logic [WIDTH-1:0] rot_exp [20] = '{
    32'h00, 32'h01, 32'h02, 32'h03, 32'h10, 32'h11, 32'h12, 32'h13,
    32'h20, 32'h21, 32'h22, 32'h23, 32'h30, 32'h31, 32'h32, 32'h33,
    32'h04, 32'h05, 32'h06, 32'h07};
  int rot_gnt [5] = '{0, 1, 2, 3, 0};
  int stall;

  initial begin
    // Reset held with every requester valid: outputs must be quiet at once.
    rst = 1'b0;
    idle_inputs();
    req_valid = '1;
    model_reset();
    clear_logs();
    #1;
    chk("rst_ready", 64'(req_ready), 64'd0);
    chk("rst_enqueue", 64'(fifo_enqueue), 64'd0);
    chk("rst_grant_valid", 64'(grant_valid), 64'd0);
    chk("rst_grant_id", 64'(grant_id), 64'd0);
    step();
    step();
    rst = 1'b1;
    clear_logs();

    // Fair rotation: everyone valid, no last, no backpressure.
    for (int k = 0; k < 26; k++) begin
      req_valid = '1; req_last = '0; fifo_full = 1'b0;
      for (int i = 0; i < N_REQ; i++) req_data[i] = WIDTH'(i * 16 + pbeat[i]);
      step();
    end
    chk("rot_enq_count", 64'(enq_log.size()), 64'd20);
    for (int i = 0; i < 20; i++) chk("rot_data", enq_at(i), 64'(rot_exp[i]));
    for (int i = 0; i < 5; i++) chk("rot_order", grant_at(i), 64'(rot_gnt[i]));
    chk("rot_bubble", enqcyc_at(4) - enqcyc_at(3), 64'd2);

    // Early last on the 2nd beat of requester 2, then regrant to 2.
    do_reset();
    for (int k = 0; k < 10; k++) begin
      idle_inputs();
      req_valid[2] = 1'b1;
      req_last[2]  = (pbeat[2] % 2) == 1;
      req_data[2]  = WIDTH'(32'h20 + pbeat[2]);
      step();
    end
    chk("last_grant0", grant_at(0), 64'd2);
    chk("last_grant1", grant_at(1), 64'd2);
    for (int i = 0; i < 4; i++) chk("last_data", enq_at(i), 64'(32'h20 + i));
    chk("last_bubble", enqcyc_at(2) - enqcyc_at(1), 64'd2);

    // Backpressure for 3 cycles after owner 1's first beat.
    do_reset();
    stall = 0;
    for (int k = 0; k < 12; k++) begin
      idle_inputs();
      req_valid[1] = pbeat[1] < 4;
      req_data[1]  = WIDTH'(32'h10 + pbeat[1]);
      fifo_full    = (pbeat[1] == 1) && (stall < 3);
      if (fifo_full) stall++;
      step();
    end
    chk("stall_enq_count", 64'(enq_log.size()), 64'd4);
    for (int i = 0; i < 4; i++) chk("stall_data", enq_at(i), 64'(32'h10 + i));
    chk("stall_gap", enqcyc_at(1) - enqcyc_at(0), 64'd4);
    chk("stall_grants", 64'(grant_log.size()), 64'd1);

    // Owner 0 withdraws after one beat; requester 3 is next.
    do_reset();
    for (int k = 0; k < 10; k++) begin
      idle_inputs();
      req_valid[0] = pbeat[0] < 1;
      req_valid[3] = 1'b1;
      for (int i = 0; i < N_REQ; i++) req_data[i] = WIDTH'(i * 16 + pbeat[i]);
      step();
    end
    chk("wd_grant0", grant_at(0), 64'd0);
    chk("wd_grant1", grant_at(1), 64'd3);
    chk("wd_data0", enq_at(0), 64'h00);
    chk("wd_data1", enq_at(1), 64'h30);

    // Reset asserted during owner 1's second beat.
    do_reset();
    for (int k = 0; k < 10 && pbeat[1] != 1; k++) begin
      idle_inputs();
      req_valid[1] = 1'b1;
      req_data[1]  = WIDTH'(32'h10 + pbeat[1]);
      step();
    end
    chk("mid_reach_beat2", 64'(pbeat[1]), 64'd1);
    req_valid[1] = 1'b1;
    req_data[1]  = 32'h11;
    #1;
    chk("mid_pre_enqueue", 64'(fifo_enqueue), 64'd1);
    rst = 1'b0;
    #1;
    chk("mid_enqueue", 64'(fifo_enqueue), 64'd0);
    chk("mid_ready", 64'(req_ready), 64'd0);
    chk("mid_grant_valid", 64'(grant_valid), 64'd0);
    model_reset();
    req_valid = 4'b1010;
    step();
    step();
    rst = 1'b1;
    clear_logs();
    for (int k = 0; k < 4; k++) begin
      req_valid = 4'b1010;
      step();
    end
    chk("mid_first_grant", grant_at(0), 64'd1);

    // Random traffic with occasional resets.
    for (int k = 0; k < 3000; k++) begin
      rst = ($urandom_range(0, 299) != 0);
      for (int i = 0; i < N_REQ; i++) begin
        req_valid[i] = ($urandom_range(0, 3) != 0);
        req_last[i]  = ($urandom_range(0, 2) == 0);
        req_data[i]  = $urandom();
      end
      fifo_full = ($urandom_range(0, 3) == 0);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
